parking_ctrl: RTL and testbench

PARKING_CTRL -- requirements
Module: parking_ctrl

---
 rtl/parking_ctrl_if.sv | 46 ++++
 rtl/parking_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_parking_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/parking_ctrl_if.sv
// Parking controller bus: groups the car-arrival, password-entry and exit
// request inputs together with the occupancy/status outputs.
//   slave  : controller side (requests in, status out)
//   master : environment side (requests out, status in)
interface parking_ctrl_if #(
  parameter int unsigned N_SLOTS = 16,
  parameter int unsigned PASS_W  = 128
);
  localparam int unsigned SW = (N_SLOTS > 2) ? $clog2(N_SLOTS) : 1;

  logic              ir;
  logic              enter1;
  logic [PASS_W-1:0] pass_entry1;
  logic              enter2;
  logic [PASS_W-1:0] pass_entry2;
  logic              exit_req;
  logic [SW-1:0]     exit_num;
  logic [PASS_W-1:0] pass_exit;

  logic [N_SLOTS-1:0] occupied;
  logic [N_SLOTS-1:0] locked;
  logic [SW:0]        count;
  logic               full;
  logic [SW-1:0]      alloc_slot;
  logic               busy;
  logic               entry_ok;
  logic               entry_fail;
  logic               entry_abort;
  logic               arrive_rej;
  logic               exit_ok;
  logic               pswd_inc;

  modport master (
    output ir, enter1, pass_entry1, enter2, pass_entry2,
           exit_req, exit_num, pass_exit,
    input  occupied, locked, count, full, alloc_slot, busy,
           entry_ok, entry_fail, entry_abort, arrive_rej, exit_ok, pswd_inc
  );

  modport slave (
    input  ir, enter1, pass_entry1, enter2, pass_entry2,
           exit_req, exit_num, pass_exit,
    output occupied, locked, count, full, alloc_slot, busy,
           entry_ok, entry_fail, entry_abort, arrive_rej, exit_ok, pswd_inc
  );
endinterface

// File: rtl/parking_ctrl.sv
// Parking slot controller.
// An arrival (ir) claims the lowest free slot and walks a two-step password
// entry (enter1 stores the salted key, enter2 confirms it). A confirmed slot
// is locked; an exit request with the matching password releases it. Failed
// exits raise pswd_inc for PSWD_HOLD cycles. All status outputs are registered.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : parking_ctrl_if.slave (requests in, occupancy/status out)
module parking_ctrl #(
  parameter int unsigned  N_SLOTS   = 16,
  parameter int unsigned  PASS_W    = 128,
  parameter logic [127:0] SALT      = 128'h70617373776f72643132333435363738,
  parameter int unsigned  TIMEOUT   = 64,
  parameter int unsigned  MAX_RETRY = 3,
  parameter int unsigned  PSWD_HOLD = 5
) (
  input  logic          clk,
  input  logic          rst,
  parking_ctrl_if.slave bus
);
  localparam int unsigned SW = (N_SLOTS > 2) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CW = SW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned HW = $clog2(PSWD_HOLD + 1);
  localparam logic [PASS_W-1:0] W_SALT = PASS_W'(SALT);

  typedef enum logic [1:0] {IDLE, WAIT_P1, WAIT_P2} state_t;

  state_t             r_state, w_state_nxt;
  logic [N_SLOTS-1:0] r_occ, w_occ_nxt;
  logic [N_SLOTS-1:0] r_lock, w_lock_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic               r_full, w_full_nxt;
  logic [SW-1:0]      r_alloc, w_alloc_nxt, w_free_idx;
  logic [TW-1:0]      r_tmo, w_tmo_nxt;
  logic [RW-1:0]      r_retry, w_retry_nxt;
  logic [HW-1:0]      r_hold;
  logic               r_entry_ok, r_entry_fail, r_entry_abort, r_arrive_rej, r_exit_ok;
  logic               w_entry_ok, w_entry_fail, w_entry_abort, w_arrive_rej, w_exit_ok;
  logic               w_exit_fail, w_key_we, w_exit_valid, w_exit_match, w_entry_match;
  logic [PASS_W-1:0]  r_key [N_SLOTS];

  // Lowest free slot from the occupancy registered before this cycle.
  always_comb begin
    w_free_idx = '0;
    for (int unsigned i = N_SLOTS; i > 0; i--)
      if (!r_occ[i-1]) w_free_idx = SW'(i - 1);
  end

  assign w_exit_valid  = {1'b0, bus.exit_num} < CW'(N_SLOTS);
  assign w_exit_match  = w_exit_valid && r_lock[bus.exit_num] &&
                         ((bus.pass_exit ^ W_SALT) == r_key[bus.exit_num]);
  assign w_entry_match = (bus.pass_entry2 ^ W_SALT) == r_key[r_alloc];

  always_comb begin
    w_state_nxt   = r_state;
    w_occ_nxt     = r_occ;
    w_lock_nxt    = r_lock;
    w_alloc_nxt   = r_alloc;
    w_tmo_nxt     = r_tmo;
    w_retry_nxt   = r_retry;
    w_key_we      = 1'b0;
    w_entry_ok    = 1'b0;
    w_entry_fail  = 1'b0;
    w_entry_abort = 1'b0;
    w_arrive_rej  = 1'b0;
    w_exit_ok     = 1'b0;
    w_exit_fail   = 1'b0;

    // Exit is independent of the FSM; it can never touch the slot under
    // entry because that slot is not locked yet.
    if (bus.exit_req) begin
      if (w_exit_match) begin
        w_occ_nxt[bus.exit_num]  = 1'b0;
        w_lock_nxt[bus.exit_num] = 1'b0;
        w_exit_ok                = 1'b1;
      end else begin
        w_exit_fail = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        if (bus.ir) begin
          if (r_full) begin
            w_arrive_rej = 1'b1;
          end else begin
            w_occ_nxt[w_free_idx] = 1'b1;
            w_alloc_nxt           = w_free_idx;
            w_tmo_nxt             = '0;
            w_retry_nxt           = '0;
            w_state_nxt           = WAIT_P1;
          end
        end
      end
      WAIT_P1, WAIT_P2: begin
        if (bus.ir) w_arrive_rej = 1'b1;
        // Retry exhaustion is seen the cycle after the last mismatch; a
        // strobe arriving on the final timeout cycle still counts.
        if (r_retry == RW'(MAX_RETRY)) begin
          w_occ_nxt[r_alloc] = 1'b0;
          w_entry_abort      = 1'b1;
          w_state_nxt        = IDLE;
        end else if (r_state == WAIT_P1 && bus.enter1) begin
          w_key_we    = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = WAIT_P2;
        end else if (r_state == WAIT_P2 && bus.enter2) begin
          if (w_entry_match) begin
            w_lock_nxt[r_alloc] = 1'b1;
            w_entry_ok          = 1'b1;
            w_state_nxt         = IDLE;
          end else begin
            w_entry_fail = 1'b1;
            w_retry_nxt  = r_retry + 1'b1;
            w_tmo_nxt    = '0;
            w_state_nxt  = WAIT_P1;
          end
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_occ_nxt[r_alloc] = 1'b0;
          w_entry_abort      = 1'b1;
          w_state_nxt        = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++)
      w_count_nxt = w_count_nxt + CW'(w_occ_nxt[i]);
    w_full_nxt = &w_occ_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_occ         <= '0;
      r_lock        <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_alloc       <= '0;
      r_tmo         <= '0;
      r_retry       <= '0;
      r_hold        <= '0;
      r_entry_ok    <= 1'b0;
      r_entry_fail  <= 1'b0;
      r_entry_abort <= 1'b0;
      r_arrive_rej  <= 1'b0;
      r_exit_ok     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_occ         <= w_occ_nxt;
      r_lock        <= w_lock_nxt;
      r_count       <= w_count_nxt;
      r_full        <= w_full_nxt;
      r_alloc       <= w_alloc_nxt;
      r_tmo         <= w_tmo_nxt;
      r_retry       <= w_retry_nxt;
      r_entry_ok    <= w_entry_ok;
      r_entry_fail  <= w_entry_fail;
      r_entry_abort <= w_entry_abort;
      r_arrive_rej  <= w_arrive_rej;
      r_exit_ok     <= w_exit_ok;
      if (w_exit_fail)       r_hold <= HW'(PSWD_HOLD);
      else if (r_hold != '0) r_hold <= r_hold - 1'b1;
    end
  end

  // Keys are not reset; a key is meaningful only while its lock bit is set.
  always_ff @(posedge clk) begin
    if (!rst && w_key_we) r_key[r_alloc] <= bus.pass_entry1 ^ W_SALT;
  end

  assign bus.occupied    = r_occ;
  assign bus.locked      = r_lock;
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.alloc_slot  = r_alloc;
  assign bus.busy        = (r_state != IDLE);
  assign bus.entry_ok    = r_entry_ok;
  assign bus.entry_fail  = r_entry_fail;
  assign bus.entry_abort = r_entry_abort;
  assign bus.arrive_rej  = r_arrive_rej;
  assign bus.exit_ok     = r_exit_ok;
  assign bus.pswd_inc    = (r_hold != '0);
endmodule

// File: tb/tb_parking_ctrl.sv
module tb_parking_ctrl;
  localparam logic [127:0] PA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] PB = 128'h0BADC0DE_11111111_22222222_33333333;
  localparam logic [127:0] PC = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  parking_ctrl_if #(.N_SLOTS(16), .PASS_W(128)) bus ();

  parking_ctrl #(
    .N_SLOTS(16), .PASS_W(128), .TIMEOUT(64), .MAX_RETRY(3), .PSWD_HOLD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pulse vector: {entry_ok, entry_fail, entry_abort, arrive_rej, exit_ok}
  logic [4:0] pulses;
  assign pulses = {bus.entry_ok, bus.entry_fail, bus.entry_abort, bus.arrive_rej, bus.exit_ok};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ir = 1'b0; bus.enter1 = 1'b0; bus.enter2 = 1'b0; bus.exit_req = 1'b0;
    bus.pass_entry1 = '0; bus.pass_entry2 = '0; bus.pass_exit = '0; bus.exit_num = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic park(input logic [127:0] p);
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    bus.enter1 = 1'b1; bus.pass_entry1 = p; tick(); bus.enter1 = 1'b0;
    bus.enter2 = 1'b1; bus.pass_entry2 = p; tick(); bus.enter2 = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.occupied !== 16'h0) begin errors++; $display("FAIL reset_occ got %h exp 0000", bus.occupied); end
    checks++; if (bus.locked !== 16'h0) begin errors++; $display("FAIL reset_lock got %h exp 0000", bus.locked); end
    checks++; if (bus.count !== 5'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_count got %0d/%b exp 0/0", bus.count, bus.full); end
    checks++; if (bus.busy !== 1'b0 || bus.alloc_slot !== 4'd0) begin errors++; $display("FAIL reset_fsm got busy %b alloc %0d exp 0 0", bus.busy, bus.alloc_slot); end
    checks++; if (pulses !== 5'b0 || bus.pswd_inc !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b/%b exp 00000/0", pulses, bus.pswd_inc); end
  endtask

  task automatic test_happy;
    do_reset();
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.alloc_slot !== 4'd0) begin errors++; $display("FAIL happy_alloc got busy %b alloc %0d exp 1 0", bus.busy, bus.alloc_slot); end
    checks++; if (bus.occupied !== 16'h0001 || bus.count !== 5'd1) begin errors++; $display("FAIL happy_occ got %h/%0d exp 0001/1", bus.occupied, bus.count); end
    // enter2 in WAIT_P1 must be ignored
    bus.enter2 = 1'b1; bus.pass_entry2 = PA; tick(); bus.enter2 = 1'b0;
    checks++; if (pulses !== 5'b0 || bus.locked !== 16'h0 || bus.busy !== 1'b1) begin errors++; $display("FAIL happy_ignore_e2 got %b/%h/%b exp 00000/0000/1", pulses, bus.locked, bus.busy); end
    bus.enter1 = 1'b1; bus.pass_entry1 = PA; tick(); bus.enter1 = 1'b0;
    checks++; if (pulses !== 5'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL happy_p1 got %b/%b exp 00000/1", pulses, bus.busy); end
    bus.enter2 = 1'b1; bus.pass_entry2 = PA; tick(); bus.enter2 = 1'b0;
    checks++; if (pulses !== 5'b10000) begin errors++; $display("FAIL happy_entry_ok got %b exp 10000", pulses); end
    checks++; if (bus.locked !== 16'h0001 || bus.count !== 5'd1 || bus.busy !== 1'b0) begin errors++; $display("FAIL happy_locked got %h/%0d/%b exp 0001/1/0", bus.locked, bus.count, bus.busy); end
    tick();
    checks++; if (pulses !== 5'b0) begin errors++; $display("FAIL happy_single_pulse got %b exp 00000", pulses); end
    // enter2 in IDLE is ignored
    bus.enter2 = 1'b1; bus.pass_entry2 = PA; tick(); bus.enter2 = 1'b0;
    checks++; if (pulses !== 5'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_e2 got %b/%b exp 00000/0", pulses, bus.busy); end
    bus.exit_req = 1'b1; bus.exit_num = 4'd0; bus.pass_exit = PA; tick(); bus.exit_req = 1'b0;
    checks++; if (pulses !== 5'b00001 || bus.pswd_inc !== 1'b0) begin errors++; $display("FAIL happy_exit got %b/%b exp 00001/0", pulses, bus.pswd_inc); end
    checks++; if (bus.occupied !== 16'h0 || bus.locked !== 16'h0 || bus.count !== 5'd0) begin errors++; $display("FAIL happy_exit_state got %h/%h/%0d exp 0/0/0", bus.occupied, bus.locked, bus.count); end
  endtask

  task automatic test_retry;
    do_reset();
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    bus.enter1 = 1'b1; bus.pass_entry1 = PA; tick(); bus.enter1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enter2 = 1'b1; bus.pass_entry2 = PB; tick(); bus.enter2 = 1'b0;
      checks++; if (pulses !== 5'b01000 || bus.busy !== 1'b1) begin errors++; $display("FAIL retry_fail%0d got %b/%b exp 01000/1", i, pulses, bus.busy); end
      if (i < 2) begin
        bus.enter1 = 1'b1; bus.pass_entry1 = PA; tick(); bus.enter1 = 1'b0;
      end
    end
    tick();
    checks++; if (pulses !== 5'b00100) begin errors++; $display("FAIL retry_abort got %b exp 00100", pulses); end
    checks++; if (bus.occupied !== 16'h0 || bus.busy !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL retry_state got %h/%b/%0d exp 0000/0/0", bus.occupied, bus.busy, bus.count); end
  endtask

  task automatic test_full;
    logic [127:0] p;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      p = PC ^ 128'(i);
      park(p);
    end
    checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.locked !== 16'hFFFF) begin errors++; $display("FAIL full_state got %b/%0d/%h exp 1/16/ffff", bus.full, bus.count, bus.locked); end
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    checks++; if (pulses !== 5'b00010 || bus.busy !== 1'b0 || bus.count !== 5'd16) begin errors++; $display("FAIL full_reject got %b/%b/%0d exp 00010/0/16", pulses, bus.busy, bus.count); end
    // exit of slot 5 and arrival in the same cycle while full
    p = PC ^ 128'd5;
    bus.ir = 1'b1; bus.exit_req = 1'b1; bus.exit_num = 4'd5; bus.pass_exit = p;
    tick(); bus.ir = 1'b0; bus.exit_req = 1'b0;
    checks++; if (pulses !== 5'b00011 || bus.busy !== 1'b0) begin errors++; $display("FAIL full_exit_arrive got %b/%b exp 00011/0", pulses, bus.busy); end
    checks++; if (bus.full !== 1'b0 || bus.count !== 5'd15 || bus.occupied !== 16'hFFDF) begin errors++; $display("FAIL full_after_exit got %b/%0d/%h exp 0/15/ffdf", bus.full, bus.count, bus.occupied); end
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    checks++; if (bus.alloc_slot !== 4'd5 || bus.full !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL full_realloc got %0d/%b/%b exp 5/1/1", bus.alloc_slot, bus.full, bus.busy); end
  endtask

  task automatic test_bad_exit;
    do_reset();
    park(PA);
    // wrong password: exactly 5 high cycles
    bus.exit_req = 1'b1; bus.exit_num = 4'd0; bus.pass_exit = PB; tick(); bus.exit_req = 1'b0;
    checks++; if (bus.exit_ok !== 1'b0 || bus.occupied !== 16'h0001 || bus.locked !== 16'h0001) begin errors++; $display("FAIL bad_exit_state got %b/%h/%h exp 0/0001/0001", bus.exit_ok, bus.occupied, bus.locked); end
    for (int c = 1; c <= 6; c++) begin
      checks++; if (bus.pswd_inc !== (c <= 5)) begin errors++; $display("FAIL bad_exit_hold c%0d got %b exp %b", c, bus.pswd_inc, (c <= 5)); end
      tick();
    end
    // unlocked slot with correct-looking password
    bus.exit_req = 1'b1; bus.exit_num = 4'd3; bus.pass_exit = PA; tick(); bus.exit_req = 1'b0;
    checks++; if (bus.pswd_inc !== 1'b1 || bus.exit_ok !== 1'b0 || bus.occupied !== 16'h0001) begin errors++; $display("FAIL bad_exit_unlocked got %b/%b/%h exp 1/0/0001", bus.pswd_inc, bus.exit_ok, bus.occupied); end
    for (int c = 0; c < 6; c++) tick();
    // reload: second failure during cycle 3 keeps pswd_inc through cycle 8
    bus.exit_req = 1'b1; bus.exit_num = 4'd0; bus.pass_exit = PB; tick(); bus.exit_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++; if (bus.pswd_inc !== (c <= 8)) begin errors++; $display("FAIL bad_exit_reload c%0d got %b exp %b", c, bus.pswd_inc, (c <= 8)); end
      bus.exit_req = (c == 3);
      tick();
      bus.exit_req = 1'b0;
    end
    // exit of the slot currently in entry (key stored, not locked) fails
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    bus.enter1 = 1'b1; bus.pass_entry1 = PC; tick(); bus.enter1 = 1'b0;
    bus.exit_req = 1'b1; bus.exit_num = 4'd1; bus.pass_exit = PC; tick(); bus.exit_req = 1'b0;
    checks++; if (bus.pswd_inc !== 1'b1 || bus.exit_ok !== 1'b0 || bus.occupied !== 16'h0003 || bus.busy !== 1'b1) begin errors++; $display("FAIL exit_in_entry got %b/%b/%h/%b exp 1/0/0003/1", bus.pswd_inc, bus.exit_ok, bus.occupied, bus.busy); end
  endtask

  task automatic test_timeout;
    do_reset();
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    for (int c = 0; c < 63; c++) tick();
    checks++; if (pulses !== 5'b0 || bus.busy !== 1'b1 || bus.occupied !== 16'h0001) begin errors++; $display("FAIL timeout_early got %b/%b/%h exp 00000/1/0001", pulses, bus.busy, bus.occupied); end
    tick();
    checks++; if (pulses !== 5'b00100 || bus.busy !== 1'b0 || bus.occupied !== 16'h0 || bus.count !== 5'd0) begin errors++; $display("FAIL timeout_abort got %b/%b/%h/%0d exp 00100/0/0000/0", pulses, bus.busy, bus.occupied, bus.count); end
  endtask

  task automatic test_reset_mid_entry;
    do_reset();
    park(PA);
    bus.ir = 1'b1; tick(); bus.ir = 1'b0;
    bus.enter1 = 1'b1; bus.pass_entry1 = PB; tick(); bus.enter1 = 1'b0;
    rst = 1'b1; bus.ir = 1'b1; bus.enter2 = 1'b1; bus.pass_entry2 = PB;
    tick();
    rst = 1'b0; bus.ir = 1'b0; bus.enter2 = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.occupied !== 16'h0 || bus.locked !== 16'h0 || bus.count !== 5'd0) begin errors++; $display("FAIL rst_mid_state got %b/%h/%h/%0d exp 0/0/0/0", bus.busy, bus.occupied, bus.locked, bus.count); end
    checks++; if (pulses !== 5'b0 || bus.alloc_slot !== 4'd0 || bus.pswd_inc !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_mid_outs got %b/%0d/%b/%b exp 00000/0/0/0", pulses, bus.alloc_slot, bus.pswd_inc, bus.full); end
    bus.enter2 = 1'b1; bus.pass_entry2 = PB; tick(); bus.enter2 = 1'b0;
    checks++; if (pulses !== 5'b0 || bus.locked !== 16'h0) begin errors++; $display("FAIL rst_mid_after got %b/%h exp 00000/0000", pulses, bus.locked); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_happy();
    test_retry();
    test_full();
    test_bad_exit();
    test_timeout();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
